// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: data word, register index and the MEM-stage FSM states.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

  localparam regbits_t REG_ZERO = 5'd0;
endpackage

// File: rtl/mem_wb_if.sv
// MEM/WB latch bundle, the WB-side counterpart of exec_mem_if.
interface mem_wb_if;
  import cpu_types_pkg::*;

  logic     wb_RegWr;
  regbits_t wb_dest_reg;
  word_t    wb_wdat;
  logic     wb_halt;

  modport mem (output wb_RegWr, wb_dest_reg, wb_wdat, wb_halt);
  modport wb  (input  wb_RegWr, wb_dest_reg, wb_wdat, wb_halt);
endinterface

// File: rtl/wb_data_sel.sv
// Combinational write-back data mux: jal > lui > MemtoReg > ALU result.
module wb_data_sel (
  input  logic        jal_i,
  input  logic        lui_i,
  input  logic        memtoreg_i,
  input  logic [31:0] pcplusfour_i,
  input  logic [15:0] imm_i,
  input  logic [31:0] dmemload_i,
  input  logic [31:0] alu_out_i,
  output logic [31:0] wdat_o
);
  always_comb begin
    wdat_o = alu_out_i;
    if (jal_i)           wdat_o = pcplusfour_i;
    else if (lui_i)      wdat_o = {imm_i, 16'h0000};
    else if (memtoreg_i) wdat_o = dmemload_i;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues the dcache request, stalls until dhit, registers MEM/WB, tracks halt.
// Optional MEM_STAT_EN adds stall_cnt / memop_cnt statistics outputs.
module mem_stage_ctrl
  import cpu_types_pkg::*;
`ifdef MEM_STAT_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        em_valid,
  input  logic        em_dREN,
  input  logic        em_dWEN,
  input  logic        em_MemtoReg,
  input  logic        em_RegWr,
  input  logic        em_jal,
  input  logic        em_lui,
  input  logic        em_halt,
  input  logic [31:0] em_alu_out,
  input  logic [31:0] em_rdat2,
  input  logic [31:0] em_pcplusfour,
  input  logic [15:0] em_imm,
  input  logic [4:0]  em_dest_reg,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        wb_RegWr,
  output logic [4:0]  wb_dest_reg,
  output logic [31:0] wb_wdat,
  output logic        wb_halt
`ifdef MEM_STAT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memop_cnt
`endif
);
  mem_state_t state_q;
  logic       wb_regwr_q, wb_halt_q;
  regbits_t   wb_dest_q;
  word_t      wb_wdat_q, wdat_sel;
  logic       active, memop, complete;

  // Gating with nRST drops the request the instant reset asserts, abandoning any in-flight op.
  assign active    = nRST & (state_q != HALTED);
  assign memop     = em_valid & (em_dREN | em_dWEN);
  assign dmemWEN   = active & memop & em_dWEN;
  assign dmemREN   = active & memop & em_dREN & ~em_dWEN;
  assign dmemaddr  = em_alu_out;
  assign dmemstore = em_rdat2;
  assign mem_stall = active & memop & ~dhit;
  assign complete  = active & em_valid & (~memop | dhit);

  wb_data_sel u_wb_sel (
    .jal_i        (em_jal),
    .lui_i        (em_lui),
    .memtoreg_i   (em_MemtoReg),
    .pcplusfour_i (em_pcplusfour),
    .imm_i        (em_imm),
    .dmemload_i   (dmemload),
    .alu_out_i    (em_alu_out),
    .wdat_o       (wdat_sel)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      wb_regwr_q <= 1'b0;
      wb_dest_q  <= REG_ZERO;
      wb_wdat_q  <= '0;
      wb_halt_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT: begin
          // A halt sharing a memop waits for its dhit, so completion gates the HALTED entry.
          if (complete && em_halt)  state_q <= HALTED;
          else if (memop && !dhit)  state_q <= WAIT;
          else                      state_q <= IDLE;
        end
        default: state_q <= HALTED;
      endcase
      wb_regwr_q <= complete & em_RegWr & (em_dest_reg != REG_ZERO);
      if (complete) begin
        wb_dest_q <= em_dest_reg;
        wb_wdat_q <= wdat_sel;
      end
      if (complete && em_halt) wb_halt_q <= 1'b1;
    end
  end

  mem_wb_if mwif ();
  assign mwif.wb_RegWr    = wb_regwr_q;
  assign mwif.wb_dest_reg = wb_dest_q;
  assign mwif.wb_wdat     = wb_wdat_q;
  assign mwif.wb_halt     = wb_halt_q;

  assign wb_RegWr    = mwif.wb_RegWr;
  assign wb_dest_reg = mwif.wb_dest_reg;
  assign wb_wdat     = mwif.wb_wdat;
  assign wb_halt     = mwif.wb_halt;

`ifdef MEM_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, memop_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      memop_cnt_q <= '0;
    end else begin
      if (mem_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (complete && memop)            memop_cnt_q <= memop_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign memop_cnt = memop_cnt_q;
`endif
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of single-cycle vectors plus stall, reset and halt sequences.
module tb_mem_stage_ctrl;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        em_valid, em_dREN, em_dWEN, em_MemtoReg, em_RegWr, em_jal, em_lui, em_halt;
  logic [31:0] em_alu_out, em_rdat2, em_pcplusfour, dmemload;
  logic [15:0] em_imm;
  logic [4:0]  em_dest_reg;
  logic        dhit;
  logic        dmemREN, dmemWEN, mem_stall, wb_RegWr, wb_halt;
  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic [4:0]  wb_dest_reg;
`ifdef MEM_STAT_EN
  logic [31:0] stall_cnt, memop_cnt;
`endif

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .em_valid(em_valid), .em_dREN(em_dREN), .em_dWEN(em_dWEN),
    .em_MemtoReg(em_MemtoReg), .em_RegWr(em_RegWr), .em_jal(em_jal),
    .em_lui(em_lui), .em_halt(em_halt), .em_alu_out(em_alu_out),
    .em_rdat2(em_rdat2), .em_pcplusfour(em_pcplusfour), .em_imm(em_imm),
    .em_dest_reg(em_dest_reg), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_RegWr(wb_RegWr),
    .wb_dest_reg(wb_dest_reg), .wb_wdat(wb_wdat), .wb_halt(wb_halt)
`ifdef MEM_STAT_EN
    , .stall_cnt(stall_cnt), .memop_cnt(memop_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid, dren, dwen, m2r, regwr, jal, lui, halt, dhit;
    logic [31:0] alu, rdat2, pc4, load;
    logic [15:0] imm;
    logic [4:0]  dest;
    logic        e_stall, e_ren, e_wen;
    logic        e_regwr, e_halt;
    logic [4:0]  e_dest;
    logic [31:0] e_wdat;
  } vec_t;

  typedef struct {
    string       nm;
    logic        regwr, halt;
    logic [4:0]  dest;
    logic [31:0] wdat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk({e.nm, ".wb_RegWr"},    {31'd0, wb_RegWr}, {31'd0, e.regwr});
    chk({e.nm, ".wb_dest_reg"}, {27'd0, wb_dest_reg}, {27'd0, e.dest});
    chk({e.nm, ".wb_wdat"},     wb_wdat, e.wdat);
    chk({e.nm, ".wb_halt"},     {31'd0, wb_halt}, {31'd0, e.halt});
  endtask

  task automatic drive(input vec_t v);
    em_valid = v.valid; em_dREN = v.dren; em_dWEN = v.dwen; em_MemtoReg = v.m2r;
    em_RegWr = v.regwr; em_jal = v.jal; em_lui = v.lui; em_halt = v.halt;
    em_alu_out = v.alu; em_rdat2 = v.rdat2; em_pcplusfour = v.pc4; em_imm = v.imm;
    em_dest_reg = v.dest; dhit = v.dhit; dmemload = v.load;
  endtask

  // One pipeline cycle: retire the previous expectation, apply v, check the request side, queue v's WB result.
  task automatic cycle(input vec_t v, input string nm);
    exp_t e;
    @(posedge CLK); #1;
    pop_chk();
    drive(v);
    #1;
    chk({nm, ".mem_stall"}, {31'd0, mem_stall}, {31'd0, v.e_stall});
    chk({nm, ".dmemREN"},   {31'd0, dmemREN},   {31'd0, v.e_ren});
    chk({nm, ".dmemWEN"},   {31'd0, dmemWEN},   {31'd0, v.e_wen});
    if (v.e_ren || v.e_wen) chk({nm, ".dmemaddr"}, dmemaddr, v.alu);
    if (v.e_wen)            chk({nm, ".dmemstore"}, dmemstore, v.rdat2);
    e.nm = nm; e.regwr = v.e_regwr; e.halt = v.e_halt; e.dest = v.e_dest; e.wdat = v.e_wdat;
    sbq.push_back(e);
  endtask

  vec_t v;

  initial begin
    vecs[0]  = '{default:'0, valid:1, dren:1, m2r:1, regwr:1, alu:32'h100, dest:5'd8, dhit:1,
                 load:32'hDEADBEEF, e_ren:1, e_regwr:1, e_dest:5'd8, e_wdat:32'hDEADBEEF};
    vecs[1]  = '{default:'0, valid:1, regwr:1, jal:1, pc4:32'h44, alu:32'h9, dest:5'd31,
                 e_regwr:1, e_dest:5'd31, e_wdat:32'h44};
    vecs[2]  = '{default:'0, valid:1, regwr:1, lui:1, imm:16'hABCD, alu:32'h1, dest:5'd5,
                 e_regwr:1, e_dest:5'd5, e_wdat:32'hABCD0000};
    vecs[3]  = '{default:'0, valid:1, regwr:1, alu:32'h77, dest:5'd0,
                 e_regwr:0, e_dest:5'd0, e_wdat:32'h77};
    vecs[4]  = '{default:'0, valid:0, dren:1, regwr:1, alu:32'h999, dest:5'd12,
                 e_regwr:0, e_dest:5'd0, e_wdat:32'h77};
    vecs[5]  = '{default:'0, valid:1, regwr:1, alu:32'h12345678, dest:5'd3,
                 e_regwr:1, e_dest:5'd3, e_wdat:32'h12345678};
    vecs[6]  = '{default:'0, valid:1, dwen:1, alu:32'h300, rdat2:32'h55, dhit:1,
                 e_wen:1, e_regwr:0, e_dest:5'd0, e_wdat:32'h300};
    vecs[7]  = '{default:'0, valid:1, dren:1, dwen:1, alu:32'h400, rdat2:32'h66, dhit:1,
                 e_wen:1, e_regwr:0, e_dest:5'd0, e_wdat:32'h400};
    vecs[8]  = '{default:'0, valid:1, regwr:1, jal:1, lui:1, m2r:1, pc4:32'h88, imm:16'h1,
                 dest:5'd2, e_regwr:1, e_dest:5'd2, e_wdat:32'h88};
    vecs[9]  = '{default:'0, valid:1, regwr:1, lui:1, m2r:1, imm:16'h0001, alu:32'h9,
                 load:32'h5, dest:5'd4, e_regwr:1, e_dest:5'd4, e_wdat:32'h00010000};
    vecs[10] = '{default:'0, valid:1, dren:1, m2r:1, regwr:1, alu:32'h104, dhit:1,
                 load:32'hCAFEF00D, dest:5'd9, e_ren:1, e_regwr:1, e_dest:5'd9, e_wdat:32'hCAFEF00D};

    // Reset with a live load presented: nothing may be requested.
    v = '{default:'0, valid:1, dren:1, alu:32'h10, dest:5'd1};
    nRST = 1'b0;
    drive(v);
    #2;
    chk("reset.dmemREN",     {31'd0, dmemREN},   32'd0);
    chk("reset.mem_stall",   {31'd0, mem_stall}, 32'd0);
    chk("reset.wb_RegWr",    {31'd0, wb_RegWr},  32'd0);
    chk("reset.wb_dest_reg", {27'd0, wb_dest_reg}, 32'd0);
    chk("reset.wb_wdat",     wb_wdat, 32'd0);
    chk("reset.wb_halt",     {31'd0, wb_halt},   32'd0);
    v = '{default:'0};
    drive(v);
    #10 nRST = 1'b1;

    for (int i = 0; i < 11; i++) cycle(vecs[i], $sformatf("vec%0d", i));

    // Store held for three cycles before dhit.
    v = '{default:'0, valid:1, dwen:1, alu:32'h200, rdat2:32'h1234, dhit:0,
          e_stall:1, e_wen:1, e_regwr:0, e_dest:5'd9, e_wdat:32'hCAFEF00D};
    for (int i = 0; i < 3; i++) cycle(v, $sformatf("sw_wait%0d", i));
    v.dhit = 1; v.e_stall = 0; v.e_dest = 5'd0; v.e_wdat = 32'h200;
    cycle(v, "sw_hit");
    v = '{default:'0, e_dest:5'd0, e_wdat:32'h200};
    cycle(v, "sw_after");
`ifdef MEM_STAT_EN
    chk("stat.stall_cnt", stall_cnt, 32'd3);
    chk("stat.memop_cnt", memop_cnt, 32'd5);
`endif

    // Reset asserted while a load is waiting.
    v = '{default:'0, valid:1, regwr:1, alu:32'h66, dest:5'd6, e_regwr:1, e_dest:5'd6, e_wdat:32'h66};
    cycle(v, "pre_rst_addu");
    v = '{default:'0, valid:1, dren:1, m2r:1, regwr:1, alu:32'h500, dest:5'd10, dhit:0,
          e_stall:1, e_ren:1, e_regwr:0, e_dest:5'd6, e_wdat:32'h66};
    cycle(v, "lw_wait0");
    cycle(v, "lw_wait1");
    @(posedge CLK); #1;
    pop_chk();
    #2 nRST = 1'b0;
    #1;
    chk("midrst.dmemREN",     {31'd0, dmemREN},   32'd0);
    chk("midrst.mem_stall",   {31'd0, mem_stall}, 32'd0);
    chk("midrst.wb_RegWr",    {31'd0, wb_RegWr},  32'd0);
    chk("midrst.wb_dest_reg", {27'd0, wb_dest_reg}, 32'd0);
    chk("midrst.wb_wdat",     wb_wdat, 32'd0);
    chk("midrst.wb_halt",     {31'd0, wb_halt},   32'd0);
    sbq.delete();
    @(posedge CLK); #2 nRST = 1'b1;
    v = '{default:'0, valid:1, dren:1, m2r:1, regwr:1, alu:32'h500, dest:5'd10, dhit:1,
          load:32'h600D, e_ren:1, e_regwr:1, e_dest:5'd10, e_wdat:32'h600D};
    cycle(v, "lw_post_rst");

    // Halt drains an addu, then sticks and blocks further requests.
    v = '{default:'0, valid:1, regwr:1, alu:32'hAA, dest:5'd7, e_regwr:1, e_dest:5'd7, e_wdat:32'hAA};
    cycle(v, "addu_pre_halt");
    v = '{default:'0, valid:1, halt:1, alu:32'h0, dest:5'd0,
          e_regwr:0, e_halt:1, e_dest:5'd0, e_wdat:32'h0};
    cycle(v, "halt");
    v = '{default:'0, valid:1, dren:1, m2r:1, regwr:1, alu:32'h700, dest:5'd11, dhit:1,
          load:32'h1111, e_regwr:0, e_halt:1, e_dest:5'd0, e_wdat:32'h0};
    for (int i = 0; i < 12; i++) cycle(v, $sformatf("halted%0d", i));
    @(posedge CLK); #1;
    pop_chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline latch in the 5-stage MIPS pipeline.
- Takes the latched EX/MEM outputs and issues the single data-memory request to the dcache, holding it until dhit.
- Stalls upstream stages while the request is outstanding, selects write-back data, and registers the MEM/WB latch.
- Tracks halt so the pipeline drains cleanly.

Parameters:
- CNT_W, 32, width of the stall-cycle counter (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- em_valid  in  1  EX/MEM latch holds a real instruction (0 = bubble)
- em_dREN  in  1  load
- em_dWEN  in  1  store
- em_MemtoReg  in  1  write-back data comes from memory
- em_RegWr  in  1  instruction writes the register file
- em_jal  in  1  write-back pc+4
- em_lui  in  1  write-back {imm,16'h0}
- em_halt  in  1  halt instruction
- em_alu_out  in  32  ALU result; also the memory address
- em_rdat2  in  32  store data
- em_pcplusfour  in  32  pc+4
- em_imm  in  16  immediate for lui
- em_dest_reg  in  5  destination register
- dhit  in  1  dcache completes the current request
- dmemload  in  32  load data, valid with dhit
- dmemREN  out  1  read request
- dmemWEN  out  1  write request
- dmemaddr  out  32  request address
- dmemstore  out  32  store data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_RegWr  out  1  MEM/WB register-file write enable
- wb_dest_reg  out  5  MEM/WB destination register
- wb_wdat  out  32  MEM/WB write data
- wb_halt  out  1  sticky halt to the system

Behaviour:
- Reset (async, nRST=0):
  - FSM goes to IDLE.
  - wb_RegWr=0, wb_dest_reg=0, wb_wdat=0, wb_halt=0.
  - dmemREN, dmemWEN and mem_stall drop to 0 immediately; a request in flight is abandoned.
- Memory-op qualifier: memop = em_valid & (em_dREN | em_dWEN).
  - dREN & dWEN together is illegal. dWEN wins and dmemREN is forced to 0.
- FSM states: IDLE, WAIT, HALTED.
  - IDLE, memop=1: drive the request combinationally (dmemaddr=em_alu_out, dmemstore=em_rdat2).
    - dhit=1 in the same cycle: complete, 0 stall cycles, stay in IDLE.
    - dhit=0: mem_stall=1, next state WAIT.
  - WAIT: hold the request with stable address/data. mem_stall = ~dhit. On dhit, complete and return to IDLE.
  - IDLE, em_valid & em_halt: capture the halt into MEM/WB, next state HALTED.
  - HALTED: wb_halt=1 (sticky), no requests, mem_stall=0, wb_RegWr=0. Exit only through reset.
  - A halt never coincides with a memop; if it does, the memop completes first, then HALTED.
- Completion semantics:
  - A non-memop valid instruction completes in the cycle it is presented.
  - A memop completes in its dhit cycle.
  - dmemREN and dmemWEN are 0 whenever memop=0 or the state is HALTED.
- MEM/WB latch, registered on the completion edge:
  - wb_RegWr = em_RegWr & (em_dest_reg != 0). Writes to $0 are suppressed.
  - wb_wdat priority: jal -> em_pcplusfour; lui -> {em_imm,16'h0}; MemtoReg -> dmemload; else em_alu_out.
  - wb_dest_reg = em_dest_reg.
- Latch when nothing completes:
  - Bubbles, and cycles with mem_stall=1, load wb_RegWr=0 (a bubble into WB).
  - wb_wdat and wb_dest_reg hold their values.
- Latency: one cycle from completion to the MEM/WB outputs.
- Store: wb_RegWr=0 after dhit.

Optional Feature:
- MEM_STAT_EN defined:
  - Adds output stall_cnt [CNT_W], which counts cycles with mem_stall=1.
  - Saturates at all-ones; resets to 0.
  - Adds output memop_cnt [CNT_W], which counts completed memops.
- MEM_STAT_EN undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg: word_t, regbits_t, and a mem_state_t enum {IDLE, WAIT, HALTED}.
- A mem_wb_if interface bundles the wb_* signals, mirroring exec_mem_if.
- Sub-module wb_data_sel: the combinational write-back mux. Everything else stays in one module.

Test Plan:
- lw, dest 8, alu_out 0x100, dhit in the same cycle, dmemload 0xDEADBEEF -> no stall; next cycle wb_RegWr=1, wb_dest_reg=8, wb_wdat=0xDEADBEEF.
- sw, addr 0x200, rdat2 0x1234, dhit after 3 cycles -> mem_stall=1 for 3 cycles with addr/data stable, dmemWEN drops after dhit, wb_RegWr=0.
- jal, dest 31, pc+4 0x44 -> wb_wdat=0x44. lui, imm 0xABCD -> wb_wdat=0xABCD0000. addu to $0 -> wb_RegWr=0.
- halt after an addu -> addu writes back, then wb_halt=1 held for 10+ cycles. A following lw with em_valid=1 -> dmemREN stays 0.
- nRST asserted mid-WAIT -> dmemREN, mem_stall and wb_* clear asynchronously. After release, a new lw completes normally.
- dREN=dWEN=1 -> only dmemWEN=1. With MEM_STAT_EN, a 3-cycle stall gives stall_cnt=3 and memop_cnt=1.
